// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared load/store unit types, size encodings and op decode helpers
package risc_pkg;

    typedef enum logic [2:0] {
        OP_LSU_LB,
        OP_LSU_LH,
        OP_LSU_LW,
        OP_LSU_LBU,
        OP_LSU_LHU,
        OP_LSU_SB,
        OP_LSU_SH,
        OP_LSU_SW
    } op_enum_lsu;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_WAIT,
        LSU_DONE
    } lsu_state_e;

    localparam logic [1:0] LSU_SIZE_B = 2'b00;
    localparam logic [1:0] LSU_SIZE_H = 2'b01;
    localparam logic [1:0] LSU_SIZE_W = 2'b10;

    function automatic logic [1:0] lsu_size(input op_enum_lsu op);
        case (op)
            OP_LSU_LB, OP_LSU_LBU, OP_LSU_SB: lsu_size = LSU_SIZE_B;
            OP_LSU_LH, OP_LSU_LHU, OP_LSU_SH: lsu_size = LSU_SIZE_H;
            default:                          lsu_size = LSU_SIZE_W;
        endcase
    endfunction

    function automatic logic lsu_is_store(input op_enum_lsu op);
        lsu_is_store = (op == OP_LSU_SB) || (op == OP_LSU_SH) || (op == OP_LSU_SW);
    endfunction

    function automatic logic lsu_misaligned(input op_enum_lsu op, input logic [1:0] addr_lo);
        case (lsu_size(op))
            LSU_SIZE_H: lsu_misaligned = addr_lo[0];
            LSU_SIZE_W: lsu_misaligned = (addr_lo != 2'b00);
            default:    lsu_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane steering: store enables/replication and load lane select/extension
module lsu_align
    import risc_pkg::*;
(
    input  op_enum_lsu  op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign half_sel = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

    // Loads fetch the whole word; only stores narrow the enables.
    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        if (lsu_is_store(op_i)) begin
            case (lsu_size(op_i))
                LSU_SIZE_B: begin
                    be_o    = 4'b0001 << addr_lo_i;
                    wdata_o = {4{wdata_i[7:0]}};
                end
                LSU_SIZE_H: begin
                    be_o    = 4'b0011 << addr_lo_i;
                    wdata_o = {2{wdata_i[15:0]}};
                end
                default: begin
                    be_o    = 4'b1111;
                    wdata_o = wdata_i;
                end
            endcase
        end
    end

    always_comb begin
        case (op_i)
            OP_LSU_LB:  rdata_o = {{24{byte_sel[7]}}, byte_sel};
            OP_LSU_LBU: rdata_o = {24'h000000, byte_sel};
            OP_LSU_LH:  rdata_o = {{16{half_sel[15]}}, half_sel};
            OP_LSU_LHU: rdata_o = {16'h0000, half_sel};
            default:    rdata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// rtl/lsu_mem_stage.sv - single-transaction load/store unit on a req/gnt/rvalid bus; LSU_TIMEOUT_EN adds a bus watchdog
module lsu_mem_stage
    import risc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lsu_valid,
    input  op_enum_lsu  lsu_op,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_ready,
    output logic        lsu_busy,
    output logic        lsu_done,
    output logic        lsu_err,
    output logic [31:0] lsu_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state_q, state_d;
    op_enum_lsu  op_q, op_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    op_enum_lsu  align_op;
    logic [1:0]  align_lo;
    logic [3:0]  align_be;
    logic [31:0] align_wdata;
    logic [31:0] align_rdata;
    logic        timeout_hit;

    // In IDLE the aligner shapes the incoming request; afterwards it extends the returned word.
    assign align_op = (state_q == LSU_IDLE) ? lsu_op : op_q;
    assign align_lo = (state_q == LSU_IDLE) ? lsu_addr[1:0] : addr_lo_q;

    lsu_align u_align (
        .op_i      (align_op),
        .addr_lo_i (align_lo),
        .wdata_i   (lsu_wdata),
        .rdata_i   (mem_rdata),
        .be_o      (align_be),
        .wdata_o   (align_wdata),
        .rdata_o   (align_rdata)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter reads N-1 during the Nth bus cycle, so the limit fires in the last allowed cycle.
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == LSU_IDLE) begin
            cnt_d = '0;
        end else if ((state_q == LSU_REQ) || (state_q == LSU_WAIT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_lo_d = addr_lo_q;
        we_d      = we_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        case (state_q)
            LSU_IDLE: begin
                if (lsu_valid) begin
                    if (lsu_misaligned(lsu_op, lsu_addr[1:0])) begin
                        state_d = LSU_DONE;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d   = LSU_REQ;
                        op_d      = lsu_op;
                        addr_lo_d = lsu_addr[1:0];
                        we_d      = lsu_is_store(lsu_op);
                        addr_d    = {lsu_addr[31:2], 2'b00};
                        be_d      = align_be;
                        wdata_d   = align_wdata;
                        err_d     = 1'b0;
                    end
                end
            end
            LSU_REQ: begin
                if (mem_gnt) begin
                    state_d = we_q ? LSU_DONE : LSU_WAIT;
                end else if (timeout_hit) begin
                    state_d = LSU_DONE;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            LSU_WAIT: begin
                if (mem_rvalid) begin
                    state_d = LSU_DONE;
                    rdata_d = align_rdata;
                end else if (timeout_hit) begin
                    state_d = LSU_DONE;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            default: begin
                state_d = LSU_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= LSU_IDLE;
            op_q      <= OP_LSU_LW;
            addr_lo_q <= 2'b00;
            we_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_lo_q <= addr_lo_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    assign lsu_ready = (state_q == LSU_IDLE);
    assign lsu_busy  = (state_q != LSU_IDLE);
    assign lsu_done  = (state_q == LSU_DONE);
    assign lsu_err   = err_q;
    assign lsu_rdata = rdata_q;
    assign mem_req   = (state_q == LSU_REQ);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb/tb_lsu_mem_stage.sv - directed self-checking bench for lsu_mem_stage
module tb_lsu_mem_stage;
    import risc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lsu_valid;
    op_enum_lsu  lsu_op;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_ready;
    logic        lsu_busy;
    logic        lsu_done;
    logic        lsu_err;
    logic [31:0] lsu_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_mem_stage #(.TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .lsu_valid  (lsu_valid),
        .lsu_op     (lsu_op),
        .lsu_addr   (lsu_addr),
        .lsu_wdata  (lsu_wdata),
        .lsu_ready  (lsu_ready),
        .lsu_busy   (lsu_busy),
        .lsu_done   (lsu_done),
        .lsu_err    (lsu_err),
        .lsu_rdata  (lsu_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic start(input op_enum_lsu op, input logic [31:0] addr, input logic [31:0] wdata);
        lsu_op    = op;
        lsu_addr  = addr;
        lsu_wdata = wdata;
        lsu_valid = 1'b1;
    endtask

    // Load with gnt in cycle 1 and rvalid in cycle 2; done expected in cycle 3.
    task automatic do_load(input string tag, input op_enum_lsu op, input logic [31:0] addr,
                           input logic [31:0] word, input logic [31:0] exp);
        start(op, addr, 32'h0);
        step();
        lsu_valid = 1'b0;
        mem_gnt   = 1'b1;
        chk({tag, "_req"}, {31'd0, mem_req}, 32'd1);
        chk({tag, "_be"}, {28'd0, mem_be}, 32'hF);
        chk({tag, "_addr"}, mem_addr, {addr[31:2], 2'b00});
        step();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = word;
        chk({tag, "_c2_done"}, {31'd0, lsu_done}, 32'd0);
        step();
        mem_rvalid = 1'b0;
        chk({tag, "_c3_done"}, {31'd0, lsu_done}, 32'd1);
        chk({tag, "_err"}, {31'd0, lsu_err}, 32'd0);
        chk({tag, "_rdata"}, lsu_rdata, exp);
        step();
    endtask

    initial begin
        rst_n      = 1'b0;
        lsu_valid  = 1'b0;
        lsu_op     = OP_LSU_LW;
        lsu_addr   = '0;
        lsu_wdata  = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        #3;
        chk("rst_ready", {31'd0, lsu_ready}, 32'd1);
        chk("rst_busy", {31'd0, lsu_busy}, 32'd0);
        chk("rst_done_err", {30'd0, lsu_done, lsu_err}, 32'd0);
        chk("rst_req_we", {30'd0, mem_req, mem_we}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_be", {28'd0, mem_be}, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_rdata", lsu_rdata, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // SW with immediate grant
        start(OP_LSU_SW, 32'h0000_0100, 32'hDEAD_BEEF);
        mem_gnt = 1'b1;
        step();
        lsu_valid = 1'b0;
        chk("sw_c1_req", {31'd0, mem_req}, 32'd1);
        chk("sw_c1_we", {31'd0, mem_we}, 32'd1);
        chk("sw_addr", mem_addr, 32'h0000_0100);
        chk("sw_be", {28'd0, mem_be}, 32'hF);
        chk("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("sw_c1_done", {31'd0, lsu_done}, 32'd0);
        step();
        chk("sw_c2_done", {31'd0, lsu_done}, 32'd1);
        chk("sw_c2_err", {31'd0, lsu_err}, 32'd0);
        chk("sw_c2_req", {31'd0, mem_req}, 32'd0);
        step();
        chk("sw_c3_ready", {31'd0, lsu_ready}, 32'd1);
        chk("sw_c3_done", {31'd0, lsu_done}, 32'd0);

        // SB on the top byte lane
        start(OP_LSU_SB, 32'h0000_0103, 32'h0000_00A5);
        step();
        lsu_valid = 1'b0;
        chk("sb_be", {28'd0, mem_be}, 32'h8);
        chk("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
        chk("sb_addr", mem_addr, 32'h0000_0100);
        step();
        mem_gnt = 1'b0;
        chk("sb_done", {31'd0, lsu_done}, 32'd1);
        step();

        do_load("lb", OP_LSU_LB, 32'h0000_0202, 32'h1180_3344, 32'hFFFF_FF80);
        do_load("lbu", OP_LSU_LBU, 32'h0000_0202, 32'h1180_3344, 32'h0000_0080);

        // Misaligned LW: straight to DONE with error
        start(OP_LSU_LW, 32'h0000_0302, 32'h0);
        step();
        lsu_valid = 1'b0;
        chk("lw_mis_req", {31'd0, mem_req}, 32'd0);
        chk("lw_mis_done", {31'd0, lsu_done}, 32'd1);
        chk("lw_mis_err", {31'd0, lsu_err}, 32'd1);
        chk("lw_mis_rdata", lsu_rdata, 32'd0);
        step();

        do_load("lhu", OP_LSU_LHU, 32'h0000_0202, 32'h1180_3344, 32'h0000_1180);

        start(OP_LSU_LH, 32'h0000_0301, 32'h0);
        step();
        lsu_valid = 1'b0;
        chk("lh_mis_req", {31'd0, mem_req}, 32'd0);
        chk("lh_mis_done", {31'd0, lsu_done}, 32'd1);
        chk("lh_mis_err", {31'd0, lsu_err}, 32'd1);
        chk("lh_mis_rdata", lsu_rdata, 32'd0);
        step();
        chk("lh_mis_idle", {31'd0, lsu_ready}, 32'd1);

        // LW with gnt delayed to cycle 3, rvalid in cycle 5, stray lsu_valid in cycle 2
        start(OP_LSU_LW, 32'h0000_0400, 32'h0);
        step();
        lsu_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            chk($sformatf("dly_req_c%0d", c), {31'd0, mem_req}, 32'd1);
            chk($sformatf("dly_addr_c%0d", c), mem_addr, 32'h0000_0400);
            chk($sformatf("dly_be_c%0d", c), {28'd0, mem_be}, 32'hF);
            chk($sformatf("dly_we_c%0d", c), {31'd0, mem_we}, 32'd0);
            chk($sformatf("dly_done_c%0d", c), {31'd0, lsu_done}, 32'd0);
            if (c == 2) start(OP_LSU_SW, 32'h0000_0500, 32'h5555_5555);
            if (c == 3) begin
                lsu_valid = 1'b0;
                mem_gnt   = 1'b1;
            end
            step();
        end
        mem_gnt = 1'b0;
        chk("dly_c4_req", {31'd0, mem_req}, 32'd0);
        chk("dly_c4_busy", {31'd0, lsu_busy}, 32'd1);
        chk("dly_c4_done", {31'd0, lsu_done}, 32'd0);
        step();
        chk("dly_c5_done", {31'd0, lsu_done}, 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_F00D;
        step();
        mem_rvalid = 1'b0;
        chk("dly_c6_done", {31'd0, lsu_done}, 32'd1);
        chk("dly_c6_rdata", lsu_rdata, 32'hCAFE_F00D);
        step();
        chk("dly_c7_done", {31'd0, lsu_done}, 32'd0);
        chk("dly_c7_ready", {31'd0, lsu_ready}, 32'd1);
        chk("dly_c7_req", {31'd0, mem_req}, 32'd0);

        // SH on the upper half; load data register must be untouched
        start(OP_LSU_SH, 32'h0000_0502, 32'h0000_1234);
        mem_gnt = 1'b1;
        step();
        lsu_valid = 1'b0;
        chk("sh_be", {28'd0, mem_be}, 32'hC);
        chk("sh_wdata", mem_wdata, 32'h1234_1234);
        chk("sh_addr", mem_addr, 32'h0000_0500);
        step();
        mem_gnt = 1'b0;
        chk("sh_done", {31'd0, lsu_done}, 32'd1);
        chk("sh_rdata_kept", lsu_rdata, 32'hCAFE_F00D);
        step();

        // Reset during WAIT
        start(OP_LSU_LW, 32'h0000_0600, 32'h0);
        step();
        lsu_valid = 1'b0;
        mem_gnt   = 1'b1;
        step();
        mem_gnt = 1'b0;
        chk("rw_pre_busy", {31'd0, lsu_busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rw_req", {31'd0, mem_req}, 32'd0);
        chk("rw_busy", {31'd0, lsu_busy}, 32'd0);
        chk("rw_ready", {31'd0, lsu_ready}, 32'd1);
        chk("rw_rdata", lsu_rdata, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("rw_post_ready", {31'd0, lsu_ready}, 32'd1);
        start(OP_LSU_SW, 32'h0000_0704, 32'h0123_4567);
        mem_gnt = 1'b1;
        step();
        lsu_valid = 1'b0;
        chk("rw_sw_addr", mem_addr, 32'h0000_0704);
        chk("rw_sw_wdata", mem_wdata, 32'h0123_4567);
        step();
        mem_gnt = 1'b0;
        chk("rw_sw_done", {31'd0, lsu_done}, 32'd1);
        chk("rw_sw_err", {31'd0, lsu_err}, 32'd0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store unit directly downstream of the ALU in the RISC-V core.
- Takes the ALU result as the effective address and rs2 as store data.
- Runs one request/grant/response transaction on the data-memory bus, handling byte-lane alignment and byte enables.
- Returns sign- or zero-extended load data to writeback, with a done/busy handshake so the core stalls while a transaction is in flight.

Parameters:
- TIMEOUT_CYCLES, 16: bus watchdog limit in cycles. Used only when LSU_TIMEOUT_EN is defined.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous reset, active low.
- lsu_valid  in  1  start a transaction; sampled only in IDLE.
- lsu_op  in  op_enum_lsu  LB/LH/LW/LBU/LHU/SB/SH/SW.
- lsu_addr  in  32  effective address (ALU result).
- lsu_wdata  in  32  store data (rs2).
- lsu_ready  out  1  high in IDLE only.
- lsu_busy  out  1  high in REQ/WAIT/DONE.
- lsu_done  out  1  one-cycle completion pulse.
- lsu_err  out  1  qualified by lsu_done: misaligned access or timeout.
- lsu_rdata  out  32  extended load data; held until the next completion.
- mem_req  out  1  bus request.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word address, bits [1:0] = 0.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_gnt  in  1  request accepted.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read word.

Behaviour:
- Reset (async, rst_n=0):
  - state = IDLE; the transaction is abandoned immediately.
  - mem_req, mem_we, lsu_done, lsu_err, lsu_busy = 0.
  - mem_addr, mem_be, mem_wdata, lsu_rdata = 0.
  - lsu_ready = 1.
- IDLE:
  - lsu_valid with an aligned access: latch op, addr, wdata, then go to REQ.
  - Misaligned access (H with addr[0]=1, or W with addr[1:0]≠0): no bus activity; go to DONE with lsu_err=1 and lsu_rdata=0.
- REQ:
  - mem_req=1; mem_addr, mem_we, mem_be, mem_wdata stay stable until mem_gnt.
  - On gnt: a store goes to DONE, a load goes to WAIT. mem_req drops the cycle after gnt.
- WAIT:
  - mem_rvalid is accepted no earlier than the cycle after gnt.
  - On rvalid: select the lane by addr[1:0], extend (sign for LB/LH, zero for LBU/LHU, none for LW), register into lsu_rdata, go to DONE.
- DONE: lsu_done=1 for exactly one cycle, then IDLE.
- Byte enables by access size:
  - B: 4'b0001<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - H: 4'b0011<<addr[1:0], wdata = {2{wdata[15:0]}}.
  - W: 4'b1111.
- Loads always drive mem_be = 4'b1111.
- Stores leave lsu_rdata unchanged.
- lsu_valid outside IDLE is ignored; there is no queuing.
- mem_gnt, mem_rvalid outside REQ/WAIT are ignored.
- Minimum latency, counted from lsu_valid at cycle 0:
  - Store with immediate gnt: done at cycle 2.
  - Load with gnt at cycle 1 and rvalid at cycle 2: done at cycle 3.
  - Misaligned access: done at cycle 1.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to REQ and increments every cycle spent in REQ or WAIT.
  - Reaching TIMEOUT_CYCLES without the awaited gnt/rvalid: drop mem_req, go to DONE with lsu_err=1 and lsu_rdata=0.
  - A late rvalid/gnt after that point is ignored.
- Undefined: no counter; the unit waits indefinitely; lsu_err is raised only on misalignment.

Decomposition:
- risc_pkg gets the additions:
  - typedef enum op_enum_lsu (values OP_LSU_LB … OP_LSU_SW).
  - The state enum (IDLE/REQ/WAIT/DONE).
  - Localparams for the size encodings.
- Sub-module lsu_align (combinational): takes op, addr[1:0], wdata and rdata; produces be, replicated wdata and extended load data. Reused later by a pipelined core.

Test Plan:
- SW addr=0x100 wdata=0xDEADBEEF, gnt immediate → mem_addr=0x100, be=1111, wdata=0xDEADBEEF, done at cycle 2, err=0.
- SB addr=0x103 wdata=0x000000A5 → be=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x100.
- LB addr=0x202, rdata=0x11803344 → lsu_rdata=0xFFFFFF80; same access as LBU → 0x00000080; LHU addr=0x202 → 0x00001180.
- LW addr=0x302 → no mem_req, done at cycle 1, err=1, rdata=0; LH addr=0x301 → same.
- LW with gnt delayed 3 cycles and rvalid 2 cycles later → request signals stable throughout; lsu_valid pulsed mid-transaction is ignored; single done pulse.
- rst_n asserted low while in WAIT → mem_req and busy drop immediately; after release, ready=1 and a following SW completes normally. With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=16, withholding gnt → done with err=1 at the 16th REQ cycle.
